// File: rtl/commit_trace_pkg.sv
// Shared types for the commit trace serializer: the buffered commit record and
// the register-file write-enable encoding used on the debug writeback port.
package commit_trace_pkg;

  typedef struct packed {
    logic        en;
    logic [4:0]  rd;
    logic [31:0] wdata;
    logic [31:0] pc;
  } commit_rec_t;

  localparam int unsigned REC_W = $bits(commit_rec_t);
  localparam logic [3:0] WEN_ALL = 4'hf;

  // Writes to r0 are architecturally invisible, so they never raise wen.
  function automatic logic [3:0] rec_wen(commit_rec_t rec);
    return (rec.en && (rec.rd != 5'd0)) ? WEN_ALL : 4'h0;
  endfunction

endpackage

// File: rtl/commit_fifo_2w1r.sv
// Record FIFO with up to two writes and one read per cycle. The caller keeps
// writes compacted (wr1 only alongside wr0) and never overfills it.
module commit_fifo_2w1r
  import commit_trace_pkg::*;
#(
  parameter int unsigned DEPTH = 16
) (
  input  logic                     sys_clk,
  input  logic                     resetn,
  input  logic                     wr0_i,
  input  logic [REC_W-1:0]         wr0_data_i,
  input  logic                     wr1_i,
  input  logic [REC_W-1:0]         wr1_data_i,
  input  logic                     rd_i,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic [REC_W-1:0]         head_o
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  logic [REC_W-1:0] mem_q [DEPTH];
  logic [PtrW-1:0]  wptr_q, wptr_d, wptr_nxt;
  logic [PtrW-1:0]  rptr_q, rptr_d;
  logic [CntW-1:0]  count_q, count_d;

  always_comb begin
    // Power-of-two depth lets the pointers wrap by plain overflow.
    wptr_nxt = wptr_q + PtrW'(1);
    wptr_d   = wptr_q + PtrW'(wr0_i) + PtrW'(wr1_i);
    rptr_d   = rptr_q + PtrW'(rd_i);
    count_d  = count_q + CntW'(wr0_i) + CntW'(wr1_i) - CntW'(rd_i);
  end

  always_ff @(posedge sys_clk) begin
    if (!resetn) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge sys_clk) begin
    if (wr0_i) mem_q[wptr_q]   <= wr0_data_i;
    if (wr1_i) mem_q[wptr_nxt] <= wr1_data_i;
  end

  assign count_o = count_q;
  assign head_o  = mem_q[rptr_q];

endmodule

// File: rtl/commit_trace_serializer.sv
// Serializes up to two commits per cycle into a single-issue debug writeback
// stream, with stall request, sticky overflow flag and emitted-record counter.
module commit_trace_serializer
  import commit_trace_pkg::*;
#(
  parameter int unsigned DEPTH     = 16,
  parameter int unsigned AF_MARGIN = 2
) (
  input  logic        sys_clk,
  input  logic        resetn,
  input  logic        c0_valid,
  input  logic        c0_en,
  input  logic [4:0]  c0_rd,
  input  logic [31:0] c0_wdata,
  input  logic [31:0] c0_pc,
  input  logic        c1_valid,
  input  logic        c1_en,
  input  logic [4:0]  c1_rd,
  input  logic [31:0] c1_wdata,
  input  logic [31:0] c1_pc,
  output logic        stall_req,
  output logic [31:0] debug_wb_pc,
  output logic [3:0]  debug_wb_rf_wen,
  output logic [4:0]  debug_wb_rf_wnum,
  output logic [31:0] debug_wb_rf_wdata,
  output logic [31:0] inst_cnt,
  output logic        overflow
);

  localparam int unsigned CntW = $clog2(DEPTH) + 1;

  commit_rec_t      c0_rec, c1_rec, slot0_rec;
  commit_rec_t      out_q, out_d;
  logic [REC_W-1:0] head;
  logic [CntW-1:0]  count;
  logic [31:0]      free;
  logic [31:0]      inst_cnt_q, inst_cnt_d;
  logic             overflow_q, overflow_d;
  logic             deq, have0, have1, acc0, acc1, drop;

  assign c0_rec = '{en: c0_en, rd: c0_rd, wdata: c0_wdata, pc: c0_pc};
  assign c1_rec = '{en: c1_en, rd: c1_rd, wdata: c1_wdata, pc: c1_pc};

  always_comb begin
    deq   = (count != '0);
    // A pop this edge frees a slot for this edge's writes.
    free  = DEPTH - 32'(count) + 32'(deq);
    have0 = c0_valid | c1_valid;
    have1 = c0_valid & c1_valid;
    slot0_rec = c0_valid ? c0_rec : c1_rec;
    acc0  = have0 && (free >= 32'd1);
    acc1  = have1 && (free >= 32'd2);
    drop  = (have0 && !acc0) || (have1 && !acc1);
    out_d      = deq ? commit_rec_t'(head) : '0;
    inst_cnt_d = inst_cnt_q + 32'(deq);
    overflow_d = overflow_q | drop;
  end

  commit_fifo_2w1r #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .sys_clk    (sys_clk),
    .resetn     (resetn),
    .wr0_i      (acc0),
    .wr0_data_i (slot0_rec),
    .wr1_i      (acc1),
    .wr1_data_i (c1_rec),
    .rd_i       (deq),
    .count_o    (count),
    .head_o     (head)
  );

  always_ff @(posedge sys_clk) begin
    if (!resetn) begin
      out_q      <= '0;
      inst_cnt_q <= '0;
      overflow_q <= 1'b0;
    end else begin
      out_q      <= out_d;
      inst_cnt_q <= inst_cnt_d;
      overflow_q <= overflow_d;
    end
  end

  assign stall_req         = (DEPTH - 32'(count)) <= AF_MARGIN;
  assign debug_wb_pc       = out_q.pc;
  assign debug_wb_rf_wen   = rec_wen(out_q);
  assign debug_wb_rf_wnum  = out_q.rd;
  assign debug_wb_rf_wdata = out_q.wdata;
  assign inst_cnt          = inst_cnt_q;
  assign overflow          = overflow_q;

endmodule

// File: tb/tb_commit_trace_serializer.sv
// Self-checking bench for commit_trace_serializer: directed scenarios plus
// randomized traffic compared against a queue-based reference model.
module tb_commit_trace_serializer;

  localparam int DEPTH     = 16;
  localparam int AF_MARGIN = 2;

  typedef struct {
    bit        en;
    bit [4:0]  rd;
    bit [31:0] wdata;
    bit [31:0] pc;
  } rec_t;

  logic        sys_clk = 1'b0;
  logic        resetn;
  logic        c0_valid, c0_en, c1_valid, c1_en;
  logic [4:0]  c0_rd, c1_rd;
  logic [31:0] c0_wdata, c0_pc, c1_wdata, c1_pc;
  logic        stall_req, overflow;
  logic [31:0] debug_wb_pc, debug_wb_rf_wdata, inst_cnt;
  logic [3:0]  debug_wb_rf_wen;
  logic [4:0]  debug_wb_rf_wnum;

  int checks = 0;
  int errors = 0;

  rec_t        q[$];
  rec_t        m_out;
  rec_t        zr;
  int unsigned m_cnt;
  bit          m_ovf;

  always #5 sys_clk = ~sys_clk;

  commit_trace_serializer #(
    .DEPTH     (DEPTH),
    .AF_MARGIN (AF_MARGIN)
  ) dut (
    .sys_clk           (sys_clk),
    .resetn            (resetn),
    .c0_valid          (c0_valid),
    .c0_en             (c0_en),
    .c0_rd             (c0_rd),
    .c0_wdata          (c0_wdata),
    .c0_pc             (c0_pc),
    .c1_valid          (c1_valid),
    .c1_en             (c1_en),
    .c1_rd             (c1_rd),
    .c1_wdata          (c1_wdata),
    .c1_pc             (c1_pc),
    .stall_req         (stall_req),
    .debug_wb_pc       (debug_wb_pc),
    .debug_wb_rf_wen   (debug_wb_rf_wen),
    .debug_wb_rf_wnum  (debug_wb_rf_wnum),
    .debug_wb_rf_wdata (debug_wb_rf_wdata),
    .inst_cnt          (inst_cnt),
    .overflow          (overflow)
  );

  function automatic rec_t mk(bit en, bit [4:0] rd, bit [31:0] wd, bit [31:0] pc);
    rec_t r;
    r.en = en; r.rd = rd; r.wdata = wd; r.pc = pc;
    return r;
  endfunction

  function automatic rec_t rnd_rec();
    return mk(1'($urandom), 5'($urandom), $urandom, $urandom);
  endfunction

  function automatic logic [106:0] obs();
    return {debug_wb_pc, debug_wb_rf_wen, debug_wb_rf_wnum, debug_wb_rf_wdata,
            inst_cnt, stall_req, overflow};
  endfunction

  function automatic logic [106:0] expv();
    logic [3:0] w;
    logic       s;
    w = (m_out.en && m_out.rd != 5'd0) ? 4'hf : 4'h0;
    s = (DEPTH - q.size()) <= AF_MARGIN;
    return {m_out.pc, w, m_out.rd, m_out.wdata, m_cnt, s, m_ovf};
  endfunction

  task automatic model_reset();
    q.delete();
    m_out = zr;
    m_cnt = 0;
    m_ovf = 1'b0;
  endtask

  // One clock edge of the reference: pop oldest into the output, then admit
  // the committed records in slot order while room remains.
  task automatic model_step(input bit v0, input rec_t r0, input bit v1, input rec_t r1);
    if (q.size() > 0) begin
      m_out = q.pop_front();
      m_cnt++;
    end else begin
      m_out = zr;
    end
    if (v0) begin
      if (q.size() < DEPTH) q.push_back(r0);
      else m_ovf = 1'b1;
    end
    if (v1) begin
      if (q.size() < DEPTH) q.push_back(r1);
      else m_ovf = 1'b1;
    end
  endtask

  task automatic apply_reset();
    c0_valid = 1'b0;
    c1_valid = 1'b0;
    resetn   = 1'b0;
    @(posedge sys_clk);
    model_reset();
    #1;
    resetn = 1'b1;
  endtask

  task automatic do_cycle(input bit v0, input rec_t r0, input bit v1, input rec_t r1);
    c0_valid = v0; c0_en = r0.en; c0_rd = r0.rd; c0_wdata = r0.wdata; c0_pc = r0.pc;
    c1_valid = v1; c1_en = r1.en; c1_rd = r1.rd; c1_wdata = r1.wdata; c1_pc = r1.pc;
    @(posedge sys_clk);
    model_step(v0, r0, v1, r1);
    #1;
    c0_valid = 1'b0;
    c1_valid = 1'b0;
  endtask

  task automatic idle();
    do_cycle(1'b0, zr, 1'b0, zr);
  endtask

  task automatic test_reset();
    apply_reset();
    apply_reset();
    checks++;
    if (obs() !== 107'b0) begin
      errors++;
      $display("FAIL reset_outputs got %h want 0", obs());
    end
    idle();
    checks++;
    if (obs() !== expv()) begin
      errors++;
      $display("FAIL reset_idle got %h want %h", obs(), expv());
    end
  endtask

  task automatic test_single();
    do_cycle(1'b1, mk(1'b1, 5'd5, 32'h12345678, 32'hbfc00000), 1'b0, zr);
    checks++;
    if (debug_wb_pc !== 32'h0) begin
      errors++;
      $display("FAIL single_k1_no_bypass got pc %h want 0", debug_wb_pc);
    end
    idle();
    checks++;
    if ({debug_wb_pc, debug_wb_rf_wen, debug_wb_rf_wnum, debug_wb_rf_wdata} !==
        {32'hbfc00000, 4'hf, 5'd5, 32'h12345678}) begin
      errors++;
      $display("FAIL single_k2 got %h/%h/%h/%h want bfc00000/f/05/12345678",
               debug_wb_pc, debug_wb_rf_wen, debug_wb_rf_wnum, debug_wb_rf_wdata);
    end
    idle();
    checks++;
    if ({debug_wb_pc, debug_wb_rf_wen, inst_cnt} !== {32'h0, 4'h0, 32'd1}) begin
      errors++;
      $display("FAIL single_k3 got pc %h wen %h cnt %0d want 0/0/1",
               debug_wb_pc, debug_wb_rf_wen, inst_cnt);
    end
  endtask

  task automatic test_dual();
    do_cycle(1'b1, mk(1'b1, 5'd3, 32'haaaa0001, 32'hbfc00010),
             1'b1, mk(1'b1, 5'd0, 32'hbbbb0002, 32'hbfc00014));
    idle();
    checks++;
    if ({debug_wb_pc, debug_wb_rf_wen, debug_wb_rf_wnum} !== {32'hbfc00010, 4'hf, 5'd3}) begin
      errors++;
      $display("FAIL dual_first got %h/%h/%h want bfc00010/f/03",
               debug_wb_pc, debug_wb_rf_wen, debug_wb_rf_wnum);
    end
    idle();
    checks++;
    if ({debug_wb_pc, debug_wb_rf_wen, debug_wb_rf_wdata} !==
        {32'hbfc00014, 4'h0, 32'hbbbb0002}) begin
      errors++;
      $display("FAIL dual_second got %h/%h/%h want bfc00014/0/bbbb0002",
               debug_wb_pc, debug_wb_rf_wen, debug_wb_rf_wdata);
    end
    checks++;
    if (inst_cnt !== 32'd3) begin
      errors++;
      $display("FAIL dual_count got %0d want 3", inst_cnt);
    end
  endtask

  task automatic test_slot1_only();
    do_cycle(1'b0, zr, 1'b1, mk(1'b1, 5'd7, 32'hc0ffee00, 32'hbfc00020));
    checks++;
    if (debug_wb_pc !== 32'h0) begin
      errors++;
      $display("FAIL slot1_k1 got pc %h want 0", debug_wb_pc);
    end
    idle();
    checks++;
    if ({debug_wb_pc, debug_wb_rf_wen, debug_wb_rf_wnum, debug_wb_rf_wdata} !==
        {32'hbfc00020, 4'hf, 5'd7, 32'hc0ffee00}) begin
      errors++;
      $display("FAIL slot1_k2 got %h/%h/%h/%h want bfc00020/f/07/c0ffee00",
               debug_wb_pc, debug_wb_rf_wen, debug_wb_rf_wnum, debug_wb_rf_wdata);
    end
    idle();
    checks++;
    if ({debug_wb_pc, inst_cnt} !== {32'h0, 32'd4}) begin
      errors++;
      $display("FAIL slot1_k3 got pc %h cnt %0d want 0/4", debug_wb_pc, inst_cnt);
    end
  endtask

  task automatic test_back_pressure();
    int first_stall = -1;
    int n = 0;
    int emitted = 0;
    apply_reset();
    for (int cyc = 0; cyc < 64; cyc++) begin
      if (stall_req === 1'b1 && first_stall < 0) first_stall = cyc;
      if (cyc < 40 && stall_req !== 1'b1) begin
        do_cycle(1'b1, mk(1'b1, 5'd1, 32'(n), 32'h1000 + 32'(4 * n)),
                 1'b1, mk(1'b1, 5'd2, 32'(n + 1), 32'h1000 + 32'(4 * (n + 1))));
        n += 2;
      end else begin
        idle();
      end
      checks++;
      if (obs() !== expv()) begin
        errors++;
        $display("FAIL bp_model cyc %0d got %h want %h", cyc, obs(), expv());
      end
      if (debug_wb_pc !== 32'h0) begin
        checks++;
        if (debug_wb_pc !== 32'h1000 + 32'(4 * emitted)) begin
          errors++;
          $display("FAIL bp_order got pc %h want %h", debug_wb_pc, 32'h1000 + 32'(4 * emitted));
        end
        emitted++;
      end
    end
    checks++;
    if (first_stall != 13) begin
      errors++;
      $display("FAIL bp_stall_rise got cycle %0d want 13", first_stall);
    end
    checks++;
    if (emitted != n || overflow !== 1'b0) begin
      errors++;
      $display("FAIL bp_complete got %0d emitted ovf %b want %0d emitted ovf 0",
               emitted, overflow, n);
    end
  endtask

  task automatic test_overflow_wrap();
    apply_reset();
    // Advance both pointers to 3 so the 15th double straddles index 15/0.
    for (int i = 0; i < 3; i++) do_cycle(1'b1, rnd_rec(), 1'b0, zr);
    for (int i = 0; i < 5; i++) idle();
    for (int i = 0; i < 14; i++) begin
      do_cycle(1'b1, rnd_rec(), 1'b1, rnd_rec());
      checks++;
      if (obs() !== expv()) begin
        errors++;
        $display("FAIL ovf_fill %0d got %h want %h", i, obs(), expv());
      end
    end
    do_cycle(1'b1, mk(1'b1, 5'd9, 32'h11110000, 32'hbfc0f000),
             1'b1, mk(1'b1, 5'd10, 32'h22220000, 32'hbfc0f004));
    checks++;
    if ({overflow, stall_req} !== 2'b01) begin
      errors++;
      $display("FAIL ovf_both_fit got ovf %b stall %b want 0/1", overflow, stall_req);
    end
    do_cycle(1'b1, mk(1'b1, 5'd11, 32'h33330000, 32'hbfc0f008),
             1'b1, mk(1'b1, 5'd12, 32'h44440000, 32'hdead0000));
    checks++;
    if (overflow !== 1'b1) begin
      errors++;
      $display("FAIL ovf_drop got ovf %b want 1", overflow);
    end
    for (int i = 0; i < 20; i++) begin
      idle();
      checks++;
      if (obs() !== expv()) begin
        errors++;
        $display("FAIL ovf_drain %0d got %h want %h", i, obs(), expv());
      end
    end
    checks++;
    if (overflow !== 1'b1) begin
      errors++;
      $display("FAIL ovf_sticky got %b want 1", overflow);
    end
  endtask

  task automatic test_reset_mid();
    apply_reset();
    for (int i = 0; i < 9; i++) do_cycle(1'b1, rnd_rec(), 1'b1, rnd_rec());
    apply_reset();
    checks++;
    if (obs() !== 107'b0) begin
      errors++;
      $display("FAIL rstmid_zero got %h want 0", obs());
    end
    idle();
    checks++;
    if (obs() !== 107'b0) begin
      errors++;
      $display("FAIL rstmid_discard got %h want 0", obs());
    end
    do_cycle(1'b1, mk(1'b1, 5'd4, 32'h5a5a5a5a, 32'hbfc00100), 1'b0, zr);
    idle();
    checks++;
    if ({debug_wb_pc, debug_wb_rf_wen, inst_cnt} !== {32'hbfc00100, 4'hf, 32'd1}) begin
      errors++;
      $display("FAIL rstmid_resume got %h/%h/%0d want bfc00100/f/1",
               debug_wb_pc, debug_wb_rf_wen, inst_cnt);
    end
  endtask

  task automatic test_random();
    bit v0, v1;
    apply_reset();
    for (int i = 0; i < 600; i++) begin
      v0 = 1'($urandom);
      v1 = 1'($urandom);
      // Mostly obey the stall, occasionally push through it to exercise drops.
      if (stall_req === 1'b1 && ($urandom % 4) != 0) begin
        v0 = 1'b0;
        v1 = 1'b0;
      end
      do_cycle(v0, rnd_rec(), v1, rnd_rec());
      checks++;
      if (obs() !== expv()) begin
        errors++;
        $display("FAIL random cyc %0d got %h want %h", i, obs(), expv());
      end
    end
  endtask

  initial begin
    resetn   = 1'b0;
    c0_valid = 1'b0; c0_en = 1'b0; c0_rd = '0; c0_wdata = '0; c0_pc = '0;
    c1_valid = 1'b0; c1_en = 1'b0; c1_rd = '0; c1_wdata = '0; c1_pc = '0;
    model_reset();
    test_reset();
    test_single();
    test_dual();
    test_slot1_only();
    test_back_pressure();
    test_overflow_wrap();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/commit_trace_serializer.md
Name: commit_trace_serializer

Overview:
- Sits between the dual-issue writeback stage and the single-stream debug writeback port (debug_wb_pc / rf_wen / rf_wnum / rf_wdata) used by the SoC trace-compare flow.
- Accepts up to two committed instructions per cycle, in slot order (slot 0 older than slot 1), and buffers them.
- Replays the buffered instructions one per cycle as single-issue debug records.
- Asserts a stall request to the core before the buffer overflows, and counts the records it has emitted.

Parameters:
- DEPTH, 16: FIFO entries; power of two, at least 4.
- AF_MARGIN, 2: stall_req asserts when fewer than AF_MARGIN+1 entries are free.

Ports:
- sys_clk  in  1  clock
- resetn  in  1  synchronous active-low reset
- c0_valid  in  1  slot 0 instruction commits this cycle
- c0_en  in  1  slot 0 writes the register file
- c0_rd  in  5  slot 0 destination register
- c0_wdata  in  32  slot 0 write data
- c0_pc  in  32  slot 0 PC
- c1_valid, c1_en, c1_rd, c1_wdata, c1_pc  in  1/1/5/32/32  slot 1, same meaning as slot 0
- stall_req  out  1  core must hold commit next cycle
- debug_wb_pc  out  32  emitted PC; 0 when idle
- debug_wb_rf_wen  out  4  4'hf when the emitted record writes a nonzero rd, else 4'h0
- debug_wb_rf_wnum  out  5  emitted rd
- debug_wb_rf_wdata  out  32  emitted wdata
- inst_cnt  out  32  number of records emitted
- overflow  out  1  sticky: a committed record was dropped

Behaviour:
- Reset (resetn=0 at a sys_clk edge) clears FIFO pointers, count, inst_cnt and overflow to 0.
  - All debug outputs reset to 0; stall_req resets to 0.
  - Reset mid-operation discards all buffered records immediately.
- Enqueue: valid slots are written in order, slot 0 first.
  - Only c0 valid: one entry.
  - Only c1 valid: one entry, occupying the slot-0 position.
  - Both valid: two entries, c0 at tail, c1 at tail+1.
  - Entry fields: {en, rd, wdata, pc}.
- Dequeue: each cycle the FIFO is non-empty, the head pops into the output register at the next edge.
  - When the FIFO is empty at an edge, the output register loads all zeros (pc=0, wen=0).
- Latency (empty FIFO, record committed in cycle k): visible on the debug outputs in cycle k+2.
  - The slot-1 record committed in the same cycle is visible in cycle k+3.
  - No bypass path from commit to outputs.
- wen is computed at output: 4'hf iff en=1 and rd!=0. Records with en=0 are still emitted with their PC.
- Count: count_next = count + n_acc - n_deq; width $clog2(DEPTH)+1.
  - Simultaneous enqueue of 2 and dequeue of 1 is legal.
  - Dequeue uses the pre-edge count, so a record cannot be written and read in the same edge.
- Pointers wrap modulo DEPTH. Two-entry writes straddling the wrap go to indices DEPTH-1 and 0.
- stall_req = (DEPTH - count) <= AF_MARGIN, decoded combinationally from the registered count.
- Overflow (core ignores stall): free = DEPTH - count + n_deq.
  - If the incoming count exceeds free, accept the oldest records that fit (c0 before c1) and drop the rest.
  - overflow is set at that edge and held until reset.
- inst_cnt increments by 1 on every edge where a FIFO record loads into the output register. It wraps at 2^32.
- Commits are never reordered or duplicated.

Decomposition:
- Shared package commit_trace_pkg:
  - commit_rec_t packed struct {en, rd[4:0], wdata[31:0], pc[31:0]}.
  - WEN_ALL = 4'hf.
- Sub-module commit_fifo_2w1r: DEPTH-entry FIFO with 0/1/2 writes per cycle and 0/1 reads per cycle.
  - Outputs: count and head.
  - Register array with muxed dual write ports.
- The top level holds the accept/drop logic, output register, stall decode and counter.

Test Plan:
- Single: c0 valid only {en=1, rd=5, wdata=0x12345678, pc=0xbfc00000} at cycle k -> cycle k+2 shows pc=0xbfc00000, wen=4'hf, wnum=5, wdata=0x12345678; cycle k+3 shows pc=0, wen=0; inst_cnt=1.
- Dual ordering: c0 pc=0xbfc00010 rd=3, c1 pc=0xbfc00014 rd=0 en=1, same cycle -> consecutive outputs 0xbfc00010 (wen=f), then 0xbfc00014 (wen=0, rd 0 suppressed).
- Slot 1 only: c1 pc=0xbfc00020 rd=7 -> emitted alone at k+2; no bubble record with pc=0 ahead of it.
- Back-pressure: DEPTH=16, both slots valid every cycle -> stall_req rises when count reaches 14; with the core obeying it, all records emit in PC order and overflow stays 0.
- Overflow and wrap: ignore stall_req, fill to count=15 with pointer near wrap, then commit two while the FIFO is dequeuing one -> both accepted (free=2), overflow=0. Next cycle, commit two at count=16 while dequeuing one -> c0 accepted, c1 dropped, overflow=1 sticky; the record at wrapped index 0 emits correctly.
- Reset mid-stream: assert resetn=0 for one edge with 10 entries buffered -> next cycle all outputs 0, inst_cnt=0, overflow=0; subsequent commits emit normally.
